// File: rtl/cm_arb_pkg.sv
// Shared types and helpers for the multi-priority locking arbiter.
package cm_arb_pkg;

    // Largest supported requester count; sizes the index/pointer fields.
    localparam int MAX_REQ = 16;
    localparam int PTR_W   = $clog2(MAX_REQ);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // One-hot (or zero) vector to binary index; zero input yields index 0.
    function automatic logic [PTR_W-1:0] oh2idx(input logic [MAX_REQ-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++)
            if (oh[i]) idx = idx | PTR_W'(i);
        return idx;
    endfunction

    // Binary index to one-hot vector.
    function automatic logic [MAX_REQ-1:0] idx2oh(input logic [PTR_W-1:0] idx);
        logic [MAX_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/cm_arb_mp_lock_rr_pick.sv
// Combinational picker: first candidate at or after ptr (wrapping), or the
// lowest-index candidate when mode=1.
module cm_arb_rr_pick
    import cm_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     cand,
    input  logic [PTR_W-1:0] ptr,
    input  logic             mode,
    output logic [N-1:0]     pick
);

    logic [N-1:0] ge_mask;
    logic [N-1:0] hi;

    // Mask of positions at or after the pointer; fixed mode opens the whole range.
    always_comb begin
        ge_mask = '0;
        for (int i = 0; i < N; i++)
            ge_mask[i] = mode ? 1'b1 : (i >= int'(ptr));
    end

    assign hi = cand & ge_mask;

    // Lowest set bit of the upper slice, otherwise wrap to lowest set bit overall.
    always_comb begin
        if (hi != '0) pick = hi & (~hi + N'(1));
        else          pick = cand & (~cand + N'(1));
    end

endmodule

// File: rtl/cm_arb_mp_lock.sv
// Multi-priority arbiter with per-level round-robin, starvation aging,
// locked-transfer hold with timeout, and runtime fixed/round-robin mode.
module cm_arb_mp_lock
    import cm_arb_pkg::*;
#(
    parameter int REQ_NUM    = 4,
    parameter int PRI_WIDTH  = 2,
    parameter int AGE_THRESH = 8,
    parameter int LOCK_MAX   = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [REQ_NUM-1:0]             req,
    input  logic [PRI_WIDTH*REQ_NUM-1:0]   pri,
    input  logic [REQ_NUM-1:0]             lock,
    input  logic                           mode,
    input  logic                           ready,
    output logic [REQ_NUM-1:0]             gnt,
    output logic [REQ_NUM-1:0]             last_gnt,
    output logic                           locked,
    output logic [REQ_NUM-1:0]             urgent
);

    localparam int LEVELS = 1 << PRI_WIDTH;
    localparam int AW     = (AGE_THRESH < 1) ? 1 : $clog2(AGE_THRESH + 1);
    localparam int LW     = (LOCK_MAX < 2) ? 1 : $clog2(LOCK_MAX);

    arb_state_e           state, state_nxt;
    logic [PTR_W-1:0]     owner, owner_nxt;
    logic [LW-1:0]        lock_cnt, lock_cnt_nxt;
    logic                 blk, blk_nxt;

    logic [PTR_W-1:0]     lvl_ptr [LEVELS];
    logic [PTR_W-1:0]     urg_ptr;
    logic [AW-1:0]        age_cnt [REQ_NUM];
    logic [AW-1:0]        age_nxt [REQ_NUM];
    logic [REQ_NUM-1:0]   urgent_nxt;

    logic [PRI_WIDTH-1:0] pmax;
    logic [REQ_NUM-1:0]   lvl_cand, urg_cand, cand, pick_oh, owner_oh;
    logic                 use_urg, owner_hold, req_own, lock_own, arb_ev;
    logic                 entry_ok, timeout;
    logic [PTR_W-1:0]     tier_ptr, gidx, ptr_nxt;

    // Highest priority level among active requesters.
    always_comb begin
        pmax = '0;
        for (int i = 0; i < REQ_NUM; i++)
            if (req[i] && (pri[i*PRI_WIDTH +: PRI_WIDTH] > pmax))
                pmax = pri[i*PRI_WIDTH +: PRI_WIDTH];
    end

    // Requesters sitting at the winning level.
    always_comb begin
        lvl_cand = '0;
        for (int i = 0; i < REQ_NUM; i++)
            lvl_cand[i] = req[i] && (pri[i*PRI_WIDTH +: PRI_WIDTH] == pmax);
    end

    // Aged requesters pre-empt the priority levels entirely.
    assign urg_cand = req & urgent;
    assign use_urg  = (urg_cand != '0);
    assign cand     = use_urg ? urg_cand : lvl_cand;
    assign tier_ptr = use_urg ? urg_ptr : lvl_ptr[pmax];

    cm_arb_rr_pick #(.N(REQ_NUM)) u_pick (
        .cand (cand),
        .ptr  (tier_ptr),
        .mode (mode),
        .pick (pick_oh)
    );

    assign owner_oh   = REQ_NUM'(idx2oh(owner));
    assign req_own    = |(req & owner_oh);
    assign lock_own   = |(lock & owner_oh);
    assign owner_hold = (state == LOCKED) && req_own;

    assign gnt     = owner_hold ? owner_oh : pick_oh;
    assign arb_ev  = ready && (gnt != '0);
    assign gidx    = oh2idx(MAX_REQ'(gnt));
    assign ptr_nxt = (gidx == PTR_W'(REQ_NUM - 1)) ? '0 : gidx + PTR_W'(1);

    // A blocked owner re-gaining the grant must not re-enter the lock.
    assign entry_ok = |(lock & gnt) && !(blk && (gidx == owner));
    assign timeout  = (LOCK_MAX != 0) && (lock_cnt == LW'(LOCK_MAX - 1));

    // Lock FSM next-state: entry on a locked grant, exit on release, drop or timeout.
    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        lock_cnt_nxt = lock_cnt;
        blk_nxt      = blk;
        // The block releases as soon as the owner drops lock, even without an event.
        if (!lock_own) blk_nxt = 1'b0;
        if (arb_ev) begin
            case (state)
                IDLE: begin
                    if (entry_ok) begin
                        state_nxt    = LOCKED;
                        owner_nxt    = gidx;
                        lock_cnt_nxt = '0;
                        blk_nxt      = 1'b0;
                    end
                end
                LOCKED: begin
                    if (!req_own) begin
                        // Owner vanished; this cycle's grant was arbitrated and may lock afresh.
                        state_nxt = IDLE;
                        if (entry_ok) begin
                            state_nxt    = LOCKED;
                            owner_nxt    = gidx;
                            lock_cnt_nxt = '0;
                            blk_nxt      = 1'b0;
                        end
                    end else if (!lock_own) begin
                        state_nxt = IDLE;
                    end else if (timeout) begin
                        state_nxt = IDLE;
                        blk_nxt   = 1'b1;
                    end else if (LOCK_MAX != 0) begin
                        lock_cnt_nxt = lock_cnt + LW'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Lock FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= '0;
            lock_cnt <= '0;
            blk      <= 1'b0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            lock_cnt <= lock_cnt_nxt;
            blk      <= blk_nxt;
        end
    end

    assign locked = (state == LOCKED);

    // Per-master age: clear on grant or idle, count losses up to the threshold.
    always_comb begin
        for (int i = 0; i < REQ_NUM; i++) begin
            age_nxt[i]    = age_cnt[i];
            if (gnt[i] || !req[i])
                age_nxt[i] = '0;
            else if (age_cnt[i] < AW'(AGE_THRESH))
                age_nxt[i] = age_cnt[i] + AW'(1);
            urgent_nxt[i] = (AGE_THRESH != 0) && (age_nxt[i] == AW'(AGE_THRESH));
        end
    end

    // Aging state and urgent flags advance only on arbitration events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REQ_NUM; i++) age_cnt[i] <= '0;
            urgent <= '0;
        end else if (arb_ev) begin
            for (int i = 0; i < REQ_NUM; i++) age_cnt[i] <= age_nxt[i];
            urgent <= urgent_nxt;
        end
    end

    // Round-robin pointers: only the tier that actually arbitrated moves; a
    // lock hold bypasses arbitration and leaves every pointer alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < LEVELS; l++) lvl_ptr[l] <= '0;
            urg_ptr <= '0;
        end else if (arb_ev && !mode && !owner_hold) begin
            if (use_urg) urg_ptr       <= ptr_nxt;
            else         lvl_ptr[pmax] <= ptr_nxt;
        end
    end

    // Grant of the last committed event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      last_gnt <= '0;
        else if (arb_ev) last_gnt <= gnt;
    end

endmodule

// File: tb/tb_cm_arb_mp_lock.sv
// Scoreboard bench: stimulus pushes expected {gnt, locked, urgent} per event,
// a negedge monitor pops and compares whenever an arbitration event is visible.
module tb_cm_arb_mp_lock;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req, lock, gnt, last_gnt, urgent;
    logic [7:0] pri;
    logic       mode, ready, locked;

    typedef struct {
        int         id;
        logic [3:0] g;
        logic       lk;
        logic [3:0] u;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    cm_arb_mp_lock #(
        .REQ_NUM(4), .PRI_WIDTH(2), .AGE_THRESH(3), .LOCK_MAX(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .pri(pri), .lock(lock),
        .mode(mode), .ready(ready), .gnt(gnt), .last_gnt(last_gnt),
        .locked(locked), .urgent(urgent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int id, input logic [3:0] act, input logic [3:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s id=%0d got=%b want=%b", nm, id, act, want);
        end
    endtask

    // Monitor: invariants every cycle, scoreboard compare on each event.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            chk("onehot", 0, {3'b0, $countones(gnt) <= 1}, 4'b0001);
            chk("subset", 0, gnt & ~req, 4'b0000);
            if (ready && gnt != 4'b0) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_event got=%b want=none", gnt);
                end else begin
                    e = exp_q.pop_front();
                    chk("gnt", e.id, gnt, e.g);
                    chk("locked", e.id, {3'b0, locked}, {3'b0, e.lk});
                    chk("urgent", e.id, urgent, e.u);
                end
            end
        end
    end

    task automatic step(input logic [3:0] r, input logic [7:0] p, input logic [3:0] l,
                        input logic m, input logic rd, input logic ev,
                        input logic [3:0] eg, input logic el, input logic [3:0] eu, input int id);
        exp_t e;
        req = r; pri = p; lock = l; mode = m; ready = rd;
        if (ev) begin
            e.id = id; e.g = eg; e.lk = el; e.u = eu;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; lock = '0; ready = 1'b0; mode = 1'b0; pri = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req = '0; pri = '0; lock = '0; mode = 1'b0; ready = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("rst_last_gnt", 0, last_gnt, 4'b0000);
        chk("rst_locked", 0, {3'b0, locked}, 4'b0000);
        chk("rst_urgent", 0, urgent, 4'b0000);
        chk("rst_gnt", 0, gnt, 4'b0000);
        rst_n = 1'b1;

        // 1: round robin at equal priority (aging kicks in for the late ones)
        step(4'b1111, 8'b01010101, 4'b0, 0, 1, 1, 4'b0001, 0, 4'b0000, 101);
        step(4'b1111, 8'b01010101, 4'b0, 0, 1, 1, 4'b0010, 0, 4'b0000, 102);
        step(4'b1111, 8'b01010101, 4'b0, 0, 1, 1, 4'b0100, 0, 4'b0000, 103);
        step(4'b1111, 8'b01010101, 4'b0, 0, 1, 1, 4'b1000, 0, 4'b1000, 104);
        step(4'b1111, 8'b01010101, 4'b0, 0, 1, 1, 4'b0001, 0, 4'b0001, 105);
        chk("t1_last_gnt", 106, last_gnt, 4'b0001);

        // 2: highest level wins; ready=0 freezes last_gnt
        do_reset();
        step(4'b0110, 8'b00110100, 4'b0, 0, 1, 1, 4'b0100, 0, 4'b0000, 201);
        step(4'b0110, 8'b00110100, 4'b0, 0, 1, 1, 4'b0100, 0, 4'b0000, 202);
        step(4'b0110, 8'b00110100, 4'b0, 0, 1, 1, 4'b0100, 0, 4'b0000, 203);
        step(4'b1001, 8'b00110100, 4'b0, 0, 0, 0, 4'b0000, 0, 4'b0000, 204);
        step(4'b1001, 8'b00110100, 4'b0, 0, 0, 0, 4'b0000, 0, 4'b0000, 205);
        chk("t2_last_gnt_hold", 206, last_gnt, 4'b0100);
        chk("t2_urgent_hold", 207, urgent, 4'b0010);

        // 3: aging promotes the low-priority loser
        do_reset();
        step(4'b0011, 8'b00000010, 4'b0, 0, 1, 1, 4'b0001, 0, 4'b0000, 301);
        step(4'b0011, 8'b00000010, 4'b0, 0, 1, 1, 4'b0001, 0, 4'b0000, 302);
        step(4'b0011, 8'b00000010, 4'b0, 0, 1, 1, 4'b0001, 0, 4'b0000, 303);
        step(4'b0011, 8'b00000010, 4'b0, 0, 1, 1, 4'b0010, 0, 4'b0010, 304);
        chk("t3_urgent_clear", 305, urgent, 4'b0000);
        step(4'b0011, 8'b00000010, 4'b0, 0, 1, 1, 4'b0001, 0, 4'b0000, 306);

        // 4: lock hold, timeout, blocked re-lock, re-lock after lock toggles low
        do_reset();
        step(4'b0100, 8'b11001111, 4'b0100, 0, 1, 1, 4'b0100, 0, 4'b0000, 401);
        step(4'b1111, 8'b11001111, 4'b0100, 0, 1, 1, 4'b0100, 1, 4'b0000, 402);
        step(4'b1111, 8'b11001111, 4'b0100, 0, 1, 1, 4'b0100, 1, 4'b0000, 403);
        step(4'b1111, 8'b11001111, 4'b0100, 0, 1, 1, 4'b0100, 1, 4'b0000, 404);
        step(4'b1111, 8'b11001111, 4'b0100, 0, 1, 1, 4'b0100, 1, 4'b1011, 405);
        step(4'b1111, 8'b11001111, 4'b0100, 0, 1, 1, 4'b0001, 0, 4'b1011, 406);
        step(4'b1111, 8'b11001111, 4'b0100, 0, 1, 1, 4'b0010, 0, 4'b1010, 407);
        step(4'b1111, 8'b11001111, 4'b0100, 0, 1, 1, 4'b1000, 0, 4'b1000, 408);
        step(4'b1111, 8'b11001111, 4'b0100, 0, 1, 1, 4'b0100, 0, 4'b0100, 409);
        step(4'b1111, 8'b11001111, 4'b0100, 0, 1, 1, 4'b0001, 0, 4'b0001, 410);
        step(4'b1111, 8'b11001111, 4'b0000, 0, 1, 1, 4'b0010, 0, 4'b0010, 411);
        step(4'b1111, 8'b11001111, 4'b0100, 0, 1, 1, 4'b1000, 0, 4'b1000, 412);
        step(4'b1111, 8'b11001111, 4'b0100, 0, 1, 1, 4'b0100, 0, 4'b0100, 413);
        step(4'b1111, 8'b11001111, 4'b0100, 0, 1, 1, 4'b0100, 1, 4'b0001, 414);

        // 5: fixed order holds pointers, then round robin resumes from them
        do_reset();
        step(4'b1010, 8'b00000000, 4'b0, 1, 1, 1, 4'b0010, 0, 4'b0000, 501);
        step(4'b1010, 8'b00000000, 4'b0, 1, 1, 1, 4'b0010, 0, 4'b0000, 502);
        step(4'b1010, 8'b00000000, 4'b0, 0, 1, 1, 4'b0010, 0, 4'b0000, 503);
        step(4'b1010, 8'b00000000, 4'b0, 0, 1, 1, 4'b1000, 0, 4'b1000, 504);
        step(4'b1010, 8'b00000000, 4'b0, 0, 1, 1, 4'b1000, 0, 4'b0000, 505);
        step(4'b1010, 8'b00000000, 4'b0, 0, 1, 1, 4'b0010, 0, 4'b0000, 506);
        step(4'b1010, 8'b00000000, 4'b0, 0, 1, 1, 4'b1000, 0, 4'b0000, 507);

        // 6: asynchronous reset while locked
        do_reset();
        step(4'b0100, 8'b00000000, 4'b0100, 0, 1, 1, 4'b0100, 0, 4'b0000, 601);
        step(4'b0100, 8'b00000000, 4'b0100, 0, 0, 0, 4'b0000, 0, 4'b0000, 602);
        chk("t6_locked", 603, {3'b0, locked}, 4'b0001);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_last_gnt", 604, last_gnt, 4'b0000);
        chk("t6_async_locked", 605, {3'b0, locked}, 4'b0000);
        chk("t6_async_urgent", 606, urgent, 4'b0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(4'b1111, 8'b01010101, 4'b0000, 0, 1, 1, 4'b0001, 0, 4'b0000, 607);
        step(4'b0000, 8'b00000000, 4'b0000, 0, 0, 0, 4'b0000, 0, 4'b0000, 608);

        chk("queue_drained", 900, exp_q.size() == 0 ? 4'b0001 : 4'b0000, 4'b0001);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cm_arb_mp_lock.md
Name: cm_arb_mp_lock

Overview:
- Next-generation multi-priority arbiter for the AHB-Lite matrix slave ports.
- Picks one requester among REQ_NUM masters:
  - highest-priority level first;
  - round-robin (or fixed order) within that level, using a separate pointer per level.
- New over the previous arbiter: starvation aging (a long-waiting master is promoted to an urgent tier), a locked-transfer hold (HMASTLOCK-style) with optional timeout, and a runtime fixed/round-robin mode.

Parameters:
- REQ_NUM, 4, number of requesters (2..16).
- PRI_WIDTH, 2, width of each requester's priority field; levels = 1<<PRI_WIDTH; larger value wins.
- AGE_THRESH, 8, arbitration events a requester may lose before promotion to urgent; 0 disables aging.
- LOCK_MAX, 16, maximum arbitration events a lock may be held; 0 means unlimited.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  REQ_NUM  request per master.
- pri  in  PRI_WIDTH*REQ_NUM  priority; field i is pri[i*PRI_WIDTH +: PRI_WIDTH].
- lock  in  REQ_NUM  master requests its grant be held (locked sequence).
- mode  in  1  0 = round-robin within level, 1 = fixed order (lowest index wins).
- ready  in  1  bus ready; the arbitration decision commits only when ready=1.
- gnt  out  REQ_NUM  combinational one-hot grant; zero when req is zero.
- last_gnt  out  REQ_NUM  registered grant of the last committed event.
- locked  out  1  registered; 1 while in state LOCKED.
- urgent  out  REQ_NUM  registered; requester aged past threshold.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - last_gnt=0, locked=0, urgent=0;
  - all age counters=0;
  - all level pointers and the urgent pointer=0;
  - state=IDLE, lock counter=0.
- Arbitration event = rising clk edge with ready=1 and gnt!=0. All state updates happen only on events; ready=0 freezes all state.
- Candidate set, state IDLE:
  - if (req & urgent)!=0, candidates = req & urgent;
  - else pmax = max pri over requesting masters, candidates = masters with req=1 and pri==pmax.
- Pick:
  - mode=0: first candidate at or after the pointer of that tier (urgent tier or level pmax), wrapping at REQ_NUM-1 to 0;
  - mode=1: lowest-index candidate.
- Pointer update on each event (mode=0 only): the tier's pointer becomes granted index+1, modulo REQ_NUM. Other tiers' pointers are unchanged. In mode=1, pointers hold.
- Aging on each event, per master i:
  - granted: counter cleared;
  - req=0: counter cleared;
  - req=1 and not granted: counter increments, saturating at AGE_THRESH;
  - urgent[i] = (counter==AGE_THRESH); with AGE_THRESH=0, urgent stays 0.
- State IDLE to LOCKED: on an event granting i while lock[i]=1. The owner is recorded, locked=1, and the lock counter is cleared.
- State LOCKED:
  - gnt = onehot(owner) while req[owner]=1, ignoring all other requests and priorities; aging still applies to the losers;
  - if req[owner]=0, gnt follows normal IDLE arbitration.
- LOCKED to IDLE, at the next event where any of these holds:
  - lock[owner]=0;
  - req[owner]=0;
  - the lock counter reaches LOCK_MAX-1 (only when LOCK_MAX!=0).
- After a timeout exit, lock[owner] is ignored (no re-lock) until the owner deasserts lock for at least one cycle. A block flag is set on timeout and cleared when lock[owner]=0.
- last_gnt <= gnt on each event. No-request cycles leave last_gnt unchanged.
- Simultaneous events: exit from LOCKED and a new grant in the same cycle are both legal; that cycle's gnt comes from IDLE arbitration when req[owner]=0.
- Reset mid-lock returns the block to IDLE with all counters cleared.
- Invariants:
  - gnt is always one-hot or zero;
  - gnt is a subset of req.

Decomposition:
- Package cm_arb_pkg:
  - state enum (IDLE, LOCKED);
  - function onehot-to-index;
  - function index-to-onehot;
  - clog2 helper constant for the pointer width.
- One sub-module, cm_arb_rr_pick (combinational): inputs candidates, pointer, mode; output one-hot pick. Instantiated once, with the pointer muxed by tier.

Test Plan (REQ_NUM=4, PRI_WIDTH=2, AGE_THRESH=3, LOCK_MAX=4 unless stated):
1. req=4'b1111, all pri=1, mode=0, ready=1 for 5 events -> gnt 0001, 0010, 0100, 1000, 0001.
2. req=4'b0110, pri[1]=1, pri[2]=3 -> gnt=0100 every event. Then ready=0 with req changed -> last_gnt holds 0100.
3. req=4'b0011, pri[0]=2, pri[1]=0, aging on:
   - master 1 loses 3 events, then urgent[1]=1;
   - event 4 gives gnt=0010, after which urgent[1] clears.
4. Master 2 granted with lock[2]=1, masters 0, 1 and 3 requesting at higher priority -> gnt=0100 for exactly 4 events, locked=1. Then timeout: master 2 is not re-locked until lock[2] toggles low.
5. mode=1, req=4'b1010, equal priority, repeated events -> gnt=0010 always. Switch to mode=0 -> gnt alternates 1000/0010 according to the held pointer.
6. rst_n pulsed low while locked=1 -> all outputs 0 asynchronously. The first event after reset with req=4'b1111 gives gnt=0001.
